// File: rtl/square_tone_synth_if.sv
// Note handshake between the song sequencer (master) and the tone synthesizer (slave).
interface square_tone_synth_if #(
  parameter int FREQ_W = 11
) ();
  logic [FREQ_W-1:0] note_freq;
  logic              note_valid;
  logic              note_ready;

  modport master (output note_freq, output note_valid, input note_ready);
  modport slave  (input note_freq, input note_valid, output note_ready);
endinterface

// File: rtl/square_tone_synth.sv
// Square-wave tone synthesizer using a fractional phase accumulator; note changes land on period ends.
// Optional macro TONE_VOLUME_PWM_EN adds a 3-bit volume input gating the high phase with an 8-step PWM.
module square_tone_synth #(
  parameter int CLK_HZ = 100000000,
  parameter int FREQ_W = 11,
  parameter int ACC_W  = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  square_tone_synth_if.slave   note,
`ifdef TONE_VOLUME_PWM_EN
  input  logic [2:0]           volume,
`endif
  output logic                 sound,
  output logic                 active,
  output logic                 period_start
);

  localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);

  logic [FREQ_W-1:0] cur_freq;
  logic [FREQ_W-1:0] pend_freq;
  logic              pend_valid;
  logic [ACC_W-1:0]  acc;
  logic              wave;

  logic [ACC_W-1:0]  sum;
  logic              wrap;
  logic              sounding;
  logic              apply;
  logic              accept;

  assign note.note_ready = ~pend_valid;

  // Adding 2*f per clock and wrapping at CLK_HZ gives 2*f toggles per second, i.e. f Hz.
  always_comb begin
    sum      = acc + ACC_W'({cur_freq, 1'b0});
    wrap     = (sum >= CLK_LIM);
    sounding = (cur_freq != '0);
    apply    = pend_valid && (!sounding || (wave && wrap));
    accept   = note.note_valid && !pend_valid;
  end

  // Apply replaces the accumulate step, so a 1->0 toggle and the switch land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_freq     <= '0;
      pend_freq    <= '0;
      pend_valid   <= 1'b0;
      acc          <= '0;
      wave         <= 1'b0;
      active       <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      if (accept) begin
        pend_freq  <= note.note_freq;
        pend_valid <= 1'b1;
      end
      if (apply) begin
        cur_freq   <= pend_freq;
        active     <= (pend_freq != '0);
        pend_valid <= 1'b0;
        acc        <= '0;
        wave       <= 1'b0;
      end else if (sounding) begin
        if (wrap) begin
          acc          <= sum - CLK_LIM;
          wave         <= ~wave;
          period_start <= ~wave;
        end else begin
          acc <= sum;
        end
      end
    end
  end

`ifdef TONE_VOLUME_PWM_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 3'd1;
    end
  end

  assign sound = wave && (pwm_cnt < volume);
`else
  assign sound = wave;
`endif

endmodule

// File: tb/tb_square_tone_synth.sv
// Self-checking bench for square_tone_synth: directed scenarios plus randomized notes against a closed-form model.
// Build with TONE_VOLUME_PWM_EN defined to exercise the volume PWM as well.
module tb_square_tone_synth;

  localparam int CLK_HZ = 100;
  localparam int FW     = 5;
  localparam int AW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sound, active, period_start;
`ifdef TONE_VOLUME_PWM_EN
  logic [2:0] volume = 3'd7;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  square_tone_synth_if #(.FREQ_W(FW)) bus ();

  square_tone_synth #(.CLK_HZ(CLK_HZ), .FREQ_W(FW), .ACC_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .note         (bus),
`ifdef TONE_VOLUME_PWM_EN
    .volume       (volume),
`endif
    .sound        (sound),
    .active       (active),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  // Reference model: the tone is k accumulate steps into note m_cur; toggles so far = floor(2*f*k/CLK_HZ).
  int m_cur = 0, m_k = 0, m_pend_f = 0, m_pwm = 0;
  int m_t_now, m_t_next;
  bit m_pend_v = 0, m_ps = 0, m_accept;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = 0; m_k = 0; m_pend_v = 0; m_pend_f = 0; m_ps = 0; m_pwm = 0;
    end else begin
      m_accept = bus.note_valid && !m_pend_v;
      m_t_now  = (2 * m_cur * m_k) / CLK_HZ;
      m_t_next = (2 * m_cur * (m_k + 1)) / CLK_HZ;
      m_ps     = 0;
      m_pwm    = (m_pwm + 1) % 8;
      if (m_pend_v && (m_cur == 0 || (m_t_now % 2 == 1 && m_t_next != m_t_now))) begin
        m_cur    = m_pend_f;
        m_k      = 0;
        m_pend_v = 0;
      end else if (m_cur != 0) begin
        if (m_t_now % 2 == 0 && m_t_next != m_t_now) m_ps = 1;
        m_k++;
      end
      if (m_accept) begin
        m_pend_f = int'(bus.note_freq);
        m_pend_v = 1;
      end
    end
  end

  function automatic logic [3:0] exp_vec();
    logic w;
    w = (((2 * m_cur * m_k) / CLK_HZ) % 2) == 1;
`ifdef TONE_VOLUME_PWM_EN
    w = w && (m_pwm < int'(volume));
`endif
    return {!m_pend_v, m_cur != 0, m_ps, w};
  endfunction

  function automatic logic [3:0] obs();
    return {bus.note_ready, active, period_start, sound};
  endfunction

  task automatic test_reset();
    bus.note_valid = 1'b0;
    bus.note_freq  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs() !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: {ready,active,pstart,sound} got %b want 1000", obs());
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL reset_idle[%0d]: got %b want 1000", i, obs());
      end
    end
  endtask

  task automatic test_first_note();
    int cnt;
    @(negedge clk);
    bus.note_freq  = 5'd10;
    bus.note_valid = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b0;
    cnt = 0;
    while (sound !== 1'b1 && cnt < 50) begin
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL first_note_model: got %b want %b", obs(), exp_vec());
      end
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 6) begin
      n_fail++;
      $display("[TB] FAIL first_note_rise: rise %0d clks after accept, want 6", cnt);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL first_note_run[%0d]: got %b want %b", i, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_switch_mid_high();
    int guard, hl, rises;
    guard = 0;
    while (period_start !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 30) begin
      n_fail++;
      $display("[TB] FAIL switch_wait_rise: no period_start within 30 clks");
    end
    hl = 1;
    bus.note_freq  = 5'd20;
    bus.note_valid = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b0;
    n_cmp++;
    if (bus.note_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL switch_ready: got %b want 0", bus.note_ready);
    end
    guard = 0;
    while (sound === 1'b1 && guard < 20) begin
      hl++;
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL switch_model: got %b want %b", obs(), exp_vec());
      end
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (hl !== 5) begin
      n_fail++;
      $display("[TB] FAIL switch_high_len: high for %0d clks, want 5", hl);
    end
    rises = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) rises++;
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL switch_run[%0d]: got %b want %b", i, obs(), exp_vec());
      end
    end
    n_cmp++;
    if (rises !== 40) begin
      n_fail++;
      $display("[TB] FAIL switch_rate: %0d periods in 200 clks, want 40", rises);
    end
  endtask

  task automatic test_rest_then_note();
    int guard;
    @(negedge clk);
    bus.note_freq  = 5'd0;
    bus.note_valid = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b0;
    guard = 0;
    while (active !== 1'b0 && guard < 20) begin
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL rest_model: got %b want %b", obs(), exp_vec());
      end
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (obs() !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL rest_silent[%0d]: got %b want 1000", i, obs());
      end
      @(negedge clk);
    end
    bus.note_freq  = 5'd25;
    bus.note_valid = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b0;
    n_cmp++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rest_accept_active: got %b want 0", active);
    end
    @(negedge clk);
    n_cmp++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rest_apply_active: got %b want 1", active);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL rest_25hz[%0d]: got %b want %b", i, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_tone();
    int guard;
    guard = 0;
    while (period_start !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.note_freq  = 5'd7;
    bus.note_valid = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b0;
    n_cmp++;
    if ({bus.note_ready, sound} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL midreset_pre: {ready,sound} got %b want 01", {bus.note_ready, sound});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got %b want 1000", obs());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL midreset_after[%0d]: got %b want 1000", i, obs());
      end
    end
  endtask

`ifdef TONE_VOLUME_PWM_EN
  task automatic test_volume();
    int rises;
    volume = 3'd4;
    @(negedge clk);
    bus.note_freq  = 5'd10;
    bus.note_valid = 1'b1;
    @(negedge clk);
    bus.note_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL volume4[%0d]: got %b want %b", i, obs(), exp_vec());
      end
    end
    volume = 3'd0;
    rises  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) rises++;
      n_cmp++;
      if (sound !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL volume0_sound[%0d]: got %b want 0", i, sound);
      end
    end
    n_cmp++;
    if (rises !== 4) begin
      n_fail++;
      $display("[TB] FAIL volume0_pstart: %0d pulses in 40 clks, want 4", rises);
    end
    volume = 3'd7;
  endtask
`endif

  task automatic test_random();
    bit last_rdy;
    last_rdy = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random[%0d]: got %b want %b", i, obs(), exp_vec());
      end
      if (!bus.note_valid || last_rdy) begin
        bus.note_valid = ($urandom_range(0, 3) == 0);
        bus.note_freq  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
`ifdef TONE_VOLUME_PWM_EN
      if ($urandom_range(0, 15) == 0) volume = 3'($urandom_range(0, 7));
`endif
      last_rdy = bus.note_ready;
    end
    bus.note_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] square_tone_synth bench start");
    test_reset();
    test_first_note();
    test_switch_mid_high();
    test_rest_then_note();
    test_reset_mid_tone();
`ifdef TONE_VOLUME_PWM_EN
    test_volume();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
